// File: rtl/booth_radix4_mul_if.sv
// Operand/result handshake bundle between the factorial control FSM and the
// radix-4 Booth multiplier.
interface booth_radix4_mul_if;
    logic signed [63:0] multiplier;
    logic signed [63:0] multiplicand;
    logic               op_start;
    logic               op_clear;
    logic               op_busy;
    logic               op_done;
    logic        [127:0] result;

    modport master (
        output multiplier, multiplicand, op_start, op_clear,
        input  op_busy, op_done, result
    );

    modport slave (
        input  multiplier, multiplicand, op_start, op_clear,
        output op_busy, op_done, result
    );
endinterface

// File: rtl/booth_radix4_mul.sv
// Sequential 64x64 signed multiplier, radix-4 modified Booth recoding,
// one recoded digit per cycle (32 iterations per product).
module booth_radix4_mul (
    input  logic                 clk,
    input  logic                 reset,
    booth_radix4_mul_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     cnt_q,   cnt_d;
    logic [129:0]   acc_q,   acc_d;
    logic [63:0]    a_q,     a_d;
    logic [63:0]    b_q,     b_d;

    logic [64:0]    b_ext;
    logic [6:0]     trip_idx;
    logic [2:0]     triplet;
    logic [65:0]    a_ext;
    logic [65:0]    pp;
    logic [129:0]   pp_ext;

    // The product always fits in 128 bits; the two guard bits only absorb
    // intermediate carries of the modular sum.
    logic           unused_acc_guard;
    assign unused_acc_guard = ^acc_q[129:128];

    // Booth digit for the current iteration and its 66-bit partial product.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        pp       = '0;
        b_ext    = {b_q, 1'b0};
        trip_idx = {1'b0, cnt_q, 1'b0};
        triplet  = b_ext[trip_idx +: 3];
        a_ext    = {{2{a_q[63]}}, a_q};
        unique case (triplet)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        pp_ext = {{64{pp[65]}}, pp} << {cnt_q, 1'b0};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        if (bus.op_clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            a_d     = '0;
            b_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.op_start) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        acc_d   = '0;
                        a_d     = bus.multiplicand;
                        b_d     = bus.multiplier;
                    end
                end
                S_BUSY: begin
                    acc_d = acc_q + pp_ext;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.op_busy = (state_q == S_BUSY);
    assign bus.op_done = (state_q == S_DONE);
    assign bus.result  = (state_q == S_DONE) ? acc_q[127:0] : 128'd0;

endmodule

// File: doc/booth_radix4_mul.md
# booth_radix4_mul

Sequential 64×64 signed multiplier using radix-4 (modified Booth) recoding. It sits directly downstream of the factorial core's control FSM and consumes the `multiplier`/`multiplicand` operand pair. It returns the 128-bit product on the `op_start`/`op_clear`/`op_done` handshake that the core already drives. It replaces the radix-2 datapath, halving iteration count to 32 cycles per product.

## Interface
Parameters: none (widths fixed at 64-bit operands, 128-bit result).

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- multiplier  in  64  signed two's-complement operand B (Booth-recoded operand)
- multiplicand  in  64  signed two's-complement operand A
- op_start  in  1  level request; sampled only in IDLE
- op_clear  in  1  abort/acknowledge; highest priority after reset
- op_busy  out  1  high in BUSY
- op_done  out  1  high in DONE
- result  out  128  signed product A×B; {high 64, low 64}

## Operation
- FSM states: IDLE, BUSY, DONE.
- Next-state priority each cycle: reset > op_clear > normal transition.
- reset or op_clear: state→IDLE, counter→0, accumulator→0, latched operands→0.
- IDLE: op_start=1 (and op_clear=0) → latch A and B, counter=0, acc=0, →BUSY. Otherwise stay.
- BUSY, iteration i=0..31:
  - Recode triplet {B[2i+1], B[2i], B[2i−1]} (B[−1]=0) to d∈{0,±1,±2}.
  - Add d·A, scaled by 4^i, to acc.
  - Partial products are formed at 66 bits signed (±2·(−2^63) must not overflow) and sign-extended to the 130-bit accumulator.
  - After i=31 → DONE.
- Operand inputs are ignored after latching; changes during BUSY have no effect.
- DONE: result = acc[127:0], exact for all inputs, including (−2^63)×(−2^63) = 2^126. Stay in DONE until op_clear=1. Dropping op_start alone does not leave DONE and does not restart.
- A restart requires op_clear (→IDLE), then op_start in IDLE.
- result = 128'b0 whenever state ≠ DONE.
- op_busy = (state==BUSY); op_done = (state==DONE). Both are registered-state decodes with no combinational path from inputs.

## Timing
- Reset values: op_busy=0, op_done=0, result=0, state=IDLE.
- op_start high at edge N (state IDLE) gives:
  - op_busy=1 in cycles N+1..N+32.
  - op_done=1 and valid result from cycle N+33.
  - Latency is 33 cycles from the sampling edge, independent of operand values; there is no early termination.
- op_clear high at edge M:
  - op_done=0, op_busy=0, result=0 from cycle M+1.
  - If op_start is still high at edge M+1, a new operation starts (IDLE samples it).
- op_start and op_clear both high in IDLE: clear wins and the state stays IDLE for that cycle.
- op_clear during BUSY: aborts immediately. Partial accumulation is discarded and op_done is never asserted for that operation.
- reset mid-operation: same as op_clear; all outputs are 0 the next cycle.
- The core's deassert-start/assert-clear in the same cycle from DONE returns the block to IDLE in one cycle.
- Counter is 5 bits; the terminal condition is counter==31 in BUSY, with no wrap into a 33rd iteration.

## Test plan
- Basic: A=5, B=6, op_start pulse held → op_busy for exactly 32 cycles, op_done at N+33, result=128'd30; result=0 before DONE.
- Signs: A=−7, B=3 → result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB; A=−7, B=−3 → 128'd21; A=0, B=64'hFFFF_FFFF_FFFF_FFFF → 0.
- Extremes: A=B=64'h8000_0000_0000_0000 → result=128'h4000_0000_0000_0000_0000_0000_0000_0000. A=64'h7FFF_FFFF_FFFF_FFFF, B=64'h8000_0000_0000_0000 → result=128'hC000_0000_0000_0000_8000_0000_0000_0000.
- Abort: start A=9, B=9, op_clear at BUSY cycle 10 → op_busy=0 next cycle, no op_done. Then start A=2, B=3 → result=6 after 33 cycles. Operands changed mid-BUSY → result still reflects the latched values.
- Handshake: op_start and op_clear both high in IDLE → stays IDLE. In DONE, drop op_start without clear → op_done stays high. Then op_clear with op_start=1 → IDLE for one cycle, then a new start.
- Chained factorial sequence mimicking the core: 1×2, 2×3, 6×4, 24×5 feeding result low back as multiplicand → 120. Apply reset at BUSY cycle 5 of a fifth op → all outputs 0 the next cycle.
